// File: rtl/io_controller_if.sv
// Processor data-memory bus as seen by the memory-mapped IO block.
// Latency: memDataOut/isIoAddr are combinational from memAddr; stores land at the next clk edge.
// Backpressure: none; the processor never stalls on IO.
// Ports: memAddr/memWrtEn/memDataIn driven by the processor (master),
//        memDataOut/isIoAddr returned by the IO block (slave).
interface io_controller_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] memAddr;
    logic             memWrtEn;
    logic [DBITS-1:0] memDataIn;
    logic [DBITS-1:0] memDataOut;
    logic             isIoAddr;

    modport master (
        output memAddr, memWrtEn, memDataIn,
        input  memDataOut, isIoAddr
    );

    modport slave (
        input  memAddr, memWrtEn, memDataIn,
        output memDataOut, isIoAddr
    );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped IO: HEX/LEDR/LEDG output registers, debounced KEY/SW read-only status.
// Latency: stores visible one clk after the store edge; reads combinational; inputs settle 2+DEBOUNCE_CYCLES clks after a change.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: clk, reset (sync, active-high); bus (slave modport of io_controller_if);
//        KEY[3:0] (raw, active-low), SW[9:0] (raw); LEDR[9:0], LEDG[7:0], HEX0..HEX3 (active-low segments g..a).
module io_controller #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [31:0]      DEBOUNCE_CYCLES = 32'd100000
) (
    input  logic                 clk,
    input  logic                 reset,
    io_controller_if.slave       bus,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3
);

    // Count value seen on the edge that completes the debounce window.
    localparam logic [31:0] DB_LAST = DEBOUNCE_CYCLES - 32'd1;

    logic [15:0] hex_reg;
    logic [9:0]  ledr_reg;
    logic [7:0]  ledg_reg;

    logic [3:0]  key_sync1, key_sync2, key_stable;
    logic [9:0]  sw_sync1, sw_sync2, sw_stable;
    logic [31:0] key_cnt, sw_cnt;

    logic        wr_hex, wr_ledr, wr_ledg;
    logic [3:0]  key_pressed;
    logic [DBITS-1:0] rd_data;
    logic        unused_data_bits;

    assign wr_hex  = bus.memWrtEn && (bus.memAddr == ADDR_HEX);
    assign wr_ledr = bus.memWrtEn && (bus.memAddr == ADDR_LEDR);
    assign wr_ledg = bus.memWrtEn && (bus.memAddr == ADDR_LEDG);

    // Only the low 16 store bits ever reach a register.
    assign unused_data_bits = ^bus.memDataIn[DBITS-1:16];

    // Output registers. Reset wins over a store in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
        end else begin
            if (wr_hex)  hex_reg  <= bus.memDataIn[15:0];
            if (wr_ledr) ledr_reg <= bus.memDataIn[9:0];
            if (wr_ledg) ledg_reg <= bus.memDataIn[7:0];
        end
    end

    // Two-flop synchronizers; KEY idles high (released) so it resets to all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync1 <= 4'b1111;
            key_sync2 <= 4'b1111;
            sw_sync1  <= '0;
            sw_sync2  <= '0;
        end else begin
            key_sync1 <= KEY;
            key_sync2 <= key_sync1;
            sw_sync1  <= SW;
            sw_sync2  <= sw_sync1;
        end
    end

    // Debounce: the whole group must disagree with its stable value for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the window.
    // The counter saturates so a degenerate DEBOUNCE_CYCLES cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_stable <= 4'b1111;
            key_cnt    <= '0;
        end else if (key_sync2 != key_stable) begin
            if (key_cnt == DB_LAST) begin
                key_stable <= key_sync2;
                key_cnt    <= '0;
            end else if (key_cnt != '1) begin
                key_cnt <= key_cnt + 32'd1;
            end
        end else begin
            key_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_stable <= '0;
            sw_cnt    <= '0;
        end else if (sw_sync2 != sw_stable) begin
            if (sw_cnt == DB_LAST) begin
                sw_stable <= sw_sync2;
                sw_cnt    <= '0;
            end else if (sw_cnt != '1) begin
                sw_cnt <= sw_cnt + 32'd1;
            end
        end else begin
            sw_cnt <= '0;
        end
    end

    // Keys read as pressed=1.
    assign key_pressed = ~key_stable;

    // Reads see registered state only, so a same-cycle store returns the old value.
    always_comb begin
        rd_data = '0;
        if (bus.memAddr == ADDR_HEX)       rd_data = DBITS'(hex_reg);
        else if (bus.memAddr == ADDR_LEDR) rd_data = DBITS'(ledr_reg);
        else if (bus.memAddr == ADDR_LEDG) rd_data = DBITS'(ledg_reg);
        else if (bus.memAddr == ADDR_KEY)  rd_data = DBITS'(key_pressed);
        else if (bus.memAddr == ADDR_SW)   rd_data = DBITS'(sw_stable);
    end

    assign bus.memDataOut = rd_data;
    // The IO window is the 32-byte block containing ADDR_HEX.
    assign bus.isIoAddr   = (bus.memAddr[DBITS-1:5] == ADDR_HEX[DBITS-1:5]);

    assign LEDR = ledr_reg;
    assign LEDG = ledg_reg;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign HEX0 = hex_glyph(hex_reg[3:0]);
    assign HEX1 = hex_glyph(hex_reg[7:4]);
    assign HEX2 = hex_glyph(hex_reg[11:8]);
    assign HEX3 = hex_glyph(hex_reg[15:12]);

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: reference model checked every cycle plus directed literal checks.
// Latency: model mirrors stores one edge later and debounce 2+8 edges after an input change.
// Backpressure: not applicable.
module tb_io_controller;
    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;
    localparam int          DB     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [7:0] LEDG;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    io_controller_if #(.DBITS(32)) bus();

    io_controller #(.DBITS(32), .DEBOUNCE_CYCLES(32'd8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .KEY  (KEY),
        .SW   (SW),
        .LEDR (LEDR),
        .LEDG (LEDG),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] hex_m;
    logic [9:0]  ledr_m;
    logic [7:0]  ledg_m;
    // Raw input history: index 0 = sampled at last edge, 1 = the edge before.
    logic [3:0]  key_hist [2];
    logic [9:0]  sw_hist  [2];
    logic [3:0]  key_st_m;
    logic [9:0]  sw_st_m;
    int          key_run, sw_run;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            hex_m = '0; ledr_m = '0; ledg_m = '0;
            key_hist[0] = 4'hF; key_hist[1] = 4'hF; key_st_m = 4'hF; key_run = 0;
            sw_hist[0]  = '0;   sw_hist[1]  = '0;   sw_st_m  = '0;   sw_run  = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (bus.memWrtEn) begin
                if (bus.memAddr == A_HEX)  hex_m  = bus.memDataIn[15:0];
                if (bus.memAddr == A_LEDR) ledr_m = bus.memDataIn[9:0];
                if (bus.memAddr == A_LEDG) ledg_m = bus.memDataIn[7:0];
            end
            // The value debounced at this edge is the raw input from two edges ago.
            if (key_hist[1] != key_st_m) begin
                key_run++;
                if (key_run == DB) begin key_st_m = key_hist[1]; key_run = 0; end
            end else key_run = 0;
            if (sw_hist[1] != sw_st_m) begin
                sw_run++;
                if (sw_run == DB) begin sw_st_m = sw_hist[1]; sw_run = 0; end
            end else sw_run = 0;
            key_hist[1] = key_hist[0]; key_hist[0] = KEY;
            sw_hist[1]  = sw_hist[0];  sw_hist[0]  = SW;
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == A_HEX)  return {16'b0, hex_m};
        if (a == A_LEDR) return {22'b0, ledr_m};
        if (a == A_LEDG) return {24'b0, ledg_m};
        if (a == A_KEY)  return {28'b0, ~key_st_m};
        if (a == A_SW)   return {22'b0, sw_st_m};
        return 32'h0;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_rdata", bus.memDataOut, exp_read(bus.memAddr));
            check("model_isio", {31'b0, bus.isIoAddr}, {31'b0, bus.memAddr[31:5] == A_HEX[31:5]});
            check("model_ledr", {22'b0, LEDR}, {22'b0, ledr_m});
            check("model_ledg", {24'b0, LEDG}, {24'b0, ledg_m});
            check("model_hex", {4'b0, HEX3, HEX2, HEX1, HEX0},
                  {4'b0, glyph[hex_m[15:12]], glyph[hex_m[11:8]], glyph[hex_m[7:4]], glyph[hex_m[3:0]]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memAddr = a; bus.memDataIn = d; bus.memWrtEn = 1'b1;
        cyc();
        bus.memWrtEn = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; KEY = 4'hF; SW = '0;
        bus.memAddr = '0; bus.memWrtEn = 1'b0; bus.memDataIn = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        check("rst_hex", {4'b0, HEX3, HEX2, HEX1, HEX0}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
        check("rst_ledr", {22'b0, LEDR}, 32'h0);
        check("rst_ledg", {24'b0, LEDG}, 32'h0);
        bus.memAddr = A_KEY; #1;
        check("rst_key_read", bus.memDataOut, 32'h0);

        // HEX store; same-cycle read returns the pre-store value
        bus.memAddr = A_HEX; bus.memDataIn = 32'h0000BEEF; bus.memWrtEn = 1'b1; #1;
        check("hex_read_pre_store", bus.memDataOut, 32'h0);
        cyc();
        bus.memWrtEn = 1'b0; #1;
        check("hex_read", bus.memDataOut, 32'h0000BEEF);
        check("hex_glyphs", {4'b0, HEX3, HEX2, HEX1, HEX0}, {4'b0, 7'h03, 7'h06, 7'h06, 7'h0E});

        // LED stores
        store(A_LEDR, 32'hFFFFFFFF);
        store(A_LEDG, 32'h000000A5);
        check("ledr_all", {22'b0, LEDR}, 32'h3FF);
        check("ledg_a5", {24'b0, LEDG}, 32'hA5);
        bus.memAddr = A_LEDR; #1;
        check("ledr_read", bus.memDataOut, 32'h3FF);

        // Stores to read-only or unmapped addresses change nothing
        store(A_SW, 32'hFFFFFFFF);
        store(A_KEY, 32'hFFFFFFFF);
        store(32'h00000100, 32'h12345678);
        check("ro_ledr", {22'b0, LEDR}, 32'h3FF);
        check("ro_ledg", {24'b0, LEDG}, 32'hA5);
        bus.memAddr = A_HEX; #1;
        check("ro_hex", bus.memDataOut, 32'h0000BEEF);
        bus.memAddr = A_SW; #1;
        check("ro_sw", bus.memDataOut, 32'h0);

        // Address decode
        bus.memAddr = 32'hF0000018; #1;
        check("unmapped_io_data", bus.memDataOut, 32'h0);
        check("unmapped_io_sel", {31'b0, bus.isIoAddr}, 32'h1);
        bus.memAddr = 32'h00000100; #1;
        check("mem_sel", {31'b0, bus.isIoAddr}, 32'h0);
        check("mem_data", bus.memDataOut, 32'h0);

        // KEY debounce: visible exactly 10 edges after the change
        bus.memAddr = A_KEY;
        KEY = 4'b1110;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("key_edge%0d", k), bus.memDataOut, (k >= 10) ? 32'h1 : 32'h0);
        end
        KEY = 4'hF;
        repeat (12) cyc();
        check("key_released", bus.memDataOut, 32'h0);

        // SW glitch shorter than the window is rejected
        bus.memAddr = A_SW;
        SW = 10'h001;
        repeat (5) cyc();
        SW = 10'h000;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            check($sformatf("sw_glitch%0d", k), bus.memDataOut, 32'h0);
        end

        // Reset mid-debounce (count 5) discards progress; also beats a store
        SW = 10'h155;
        repeat (7) cyc();
        reset = 1'b1;
        bus.memAddr = A_HEX; bus.memDataIn = 32'h00001234; bus.memWrtEn = 1'b1;
        cyc();
        reset = 1'b0; bus.memWrtEn = 1'b0; bus.memAddr = A_SW; #1;
        check("rst_beats_store", {4'b0, HEX3, HEX2, HEX1, HEX0}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
        check("rst_clears_ledr", {22'b0, LEDR}, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("sw_after_rst%0d", k), bus.memDataOut, (k >= 10) ? 32'h155 : 32'h0);
        end

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
